// File: rtl/dfu_pkg.sv
// Purpose: shared types and defaults for the DFU ping-pong bank array.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package dfu_pkg;

  // Ownership state of one buffer set.
  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'd0,
    BUF_FILLING = 2'd1,
    BUF_FULL    = 2'd2
  } buf_state_e;

  localparam int DFU_NUM_BANKS = 8;
  localparam int DFU_ES        = 16;
  localparam int DFU_DEPTH     = 256;

  // Bank address width; a single-entry bank still gets one address bit.
  function automatic int dfu_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dfu_bank_sram.sv
// Purpose: one ES-wide bank, simple dual port (sync write, registered read with valid).
// Latency: read data and rd_vld appear one cycle after rd_en; rd_dat holds when idle.
// Backpressure: none; every enabled read or write is performed.
// Ports: clk/rst (rst clears rd_vld only), wr_en/wr_addr/wr_dat write port,
//        rd_en/rd_addr read request, rd_dat/rd_vld registered read response.
module dfu_bank_sram #(
  parameter int ES     = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ES-1:0]     wr_dat,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [ES-1:0]     rd_dat,
  output logic              rd_vld
);

  logic [ES-1:0] mem_q [DEPTH];
  logic [ES-1:0] rd_dat_q, rd_dat_d;
  logic          rd_vld_q, rd_vld_d;

  always_comb begin
    rd_vld_d = rd_en;
    rd_dat_d = rd_en ? mem_q[rd_addr] : rd_dat_q;
  end

  // Storage and read data are not reset; only the valid is.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
    rd_dat_q <= rd_dat_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_vld_d;
    end
  end

  assign rd_dat = rd_dat_q;
  assign rd_vld = rd_vld_q;

endmodule

// File: rtl/dfu_pingpong_banks.sv
// Purpose: double-buffered bank array; write side fills set wp while read side owns set rp.
// Latency: read data/valid one cycle after rd_en; set close and release take effect next edge.
// Backpressure: wr_ready drops while the write set is FULL (both sets full) until rd_release.
// Ports: ar2dfu_data_in/wr_valid/wr_last/wr_ready write beats; wr_set/rd_set/set_rdy/rd_len
//        buffer status; dfu2ip_sram_rd_en/_rd_addr per-bank reads; dfu2op_sram_data_out/_vld
//        per-bank read response; rd_release hands the read set back; rd_err flags bad reads.
import dfu_pkg::*;

module dfu_pingpong_banks #(
  parameter int NUM_BANKS = DFU_NUM_BANKS,
  parameter int ES        = DFU_ES,
  parameter int DEPTH     = DFU_DEPTH,
  parameter int ADDR_W    = dfu_addr_w(DEPTH),
  parameter int DATA_W    = NUM_BANKS * ES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             ar2dfu_data_in,
  input  logic                          wr_valid,
  input  logic                          wr_last,
  output logic                          wr_ready,
  output logic                          wr_set,
  output logic                          rd_set,
  output logic                          set_rdy,
  output logic [ADDR_W:0]               rd_len,
  input  logic [NUM_BANKS-1:0]          dfu2ip_sram_rd_en,
  input  logic [NUM_BANKS*ADDR_W-1:0]   dfu2ip_sram_rd_addr,
  output logic [NUM_BANKS*ES-1:0]       dfu2op_sram_data_out,
  output logic [NUM_BANKS-1:0]          dfu2op_sram_data_out_vld,
  input  logic                          rd_release,
  output logic                          rd_err
);

  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  buf_state_e            state_q [0:1];
  buf_state_e            state_d [0:1];
  logic [ADDR_W:0]       len_q   [0:1];
  logic [ADDR_W:0]       len_d   [0:1];
  logic                  wp_q, wp_d, rp_q, rp_d;
  logic [ADDR_W:0]       wr_cnt_q, wr_cnt_d;
  // sel_q[k]: which set bank k's last accepted read came from, so held data
  // keeps coming from the same physical bank after rp swaps.
  logic [NUM_BANKS-1:0]  sel_q, sel_d;
  // dat_ok_q[k]: output shows bank data; cleared by reset and illegal reads
  // so the output reads zero without resetting the bank storage.
  logic [NUM_BANKS-1:0]  dat_ok_q, dat_ok_d;
  logic                  rd_err_q, rd_err_d;

  logic                  wr_acc, wr_close, rel_ok;
  logic [NUM_BANKS-1:0]  rd_ok, rd_bad;
  logic [DATA_W-1:0]     bank_dat [0:1];
  logic [NUM_BANKS-1:0]  bank_vld [0:1];

  assign wr_ready = (state_q[wp_q] != BUF_FULL);
  assign set_rdy  = (state_q[rp_q] == BUF_FULL);
  assign rd_len   = set_rdy ? len_q[rp_q] : '0;
  assign wr_set   = wp_q;
  assign rd_set   = rp_q;
  assign rd_err   = rd_err_q;

  assign wr_acc   = wr_valid && wr_ready;
  assign wr_close = wr_acc && (wr_last || (wr_cnt_q == CNT_LAST));
  assign rel_ok   = rd_release && set_rdy;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wp_d     = wp_q;
    rp_d     = rp_q;
    wr_cnt_d = wr_cnt_q;
    // wp == rp cannot coincide with both an accepted beat and a release:
    // one needs the set FULL, the other needs it not FULL.
    if (wr_acc) begin
      if (wr_close) begin
        state_d[wp_q] = BUF_FULL;
        len_d[wp_q]   = wr_cnt_q + CNT_ONE;
        wr_cnt_d      = '0;
        wp_d          = ~wp_q;
      end else begin
        state_d[wp_q] = BUF_FILLING;
        wr_cnt_d      = wr_cnt_q + CNT_ONE;
      end
    end
    if (rel_ok) begin
      state_d[rp_q] = BUF_EMPTY;
      rp_d          = ~rp_q;
    end
  end

  always_comb begin
    rd_ok    = '0;
    rd_bad   = '0;
    sel_d    = sel_q;
    dat_ok_d = dat_ok_q;
    for (int k = 0; k < NUM_BANKS; k++) begin
      rd_ok[k]  = dfu2ip_sram_rd_en[k] && set_rdy &&
                  ({1'b0, dfu2ip_sram_rd_addr[k*ADDR_W +: ADDR_W]} < len_q[rp_q]);
      rd_bad[k] = dfu2ip_sram_rd_en[k] && !rd_ok[k];
      if (rd_ok[k]) begin
        sel_d[k]    = rp_q;
        dat_ok_d[k] = 1'b1;
      end else if (rd_bad[k]) begin
        dat_ok_d[k] = 1'b0;
      end
    end
    rd_err_d = |rd_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q[0] <= BUF_EMPTY;
      state_q[1] <= BUF_EMPTY;
      len_q[0]   <= '0;
      len_q[1]   <= '0;
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
      wr_cnt_q   <= '0;
      sel_q      <= '0;
      dat_ok_q   <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      wr_cnt_q   <= wr_cnt_d;
      sel_q      <= sel_d;
      dat_ok_q   <= dat_ok_d;
      rd_err_q   <= rd_err_d;
    end
  end

  for (genvar s = 0; s < 2; s++) begin : g_set
    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
      dfu_bank_sram #(
        .ES     (ES),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
      ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc && (wp_q == 1'(s))),
        .wr_addr (wr_cnt_q[ADDR_W-1:0]),
        .wr_dat  (ar2dfu_data_in[k*ES +: ES]),
        .rd_en   (rd_ok[k] && (rp_q == 1'(s))),
        .rd_addr (dfu2ip_sram_rd_addr[k*ADDR_W +: ADDR_W]),
        .rd_dat  (bank_dat[s][k*ES +: ES]),
        .rd_vld  (bank_vld[s][k])
      );
    end
  end

  always_comb begin
    dfu2op_sram_data_out     = '0;
    dfu2op_sram_data_out_vld = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      dfu2op_sram_data_out[k*ES +: ES] = dat_ok_q[k] ? bank_dat[sel_q[k]][k*ES +: ES] : '0;
      dfu2op_sram_data_out_vld[k]      = bank_vld[sel_q[k]][k];
    end
  end

endmodule

// File: tb/tb_dfu_pingpong_banks.sv
module tb_dfu_pingpong_banks;

  localparam int NB = 8;
  localparam int ES = 16;
  localparam int DEPTH = 256;
  localparam int AW = 8;
  localparam int DW = NB * ES;

  logic              clk = 1'b0;
  logic              rst;
  logic [DW-1:0]     ar2dfu_data_in;
  logic              wr_valid, wr_last, wr_ready;
  logic              wr_set, rd_set, set_rdy;
  logic [AW:0]       rd_len;
  logic [NB-1:0]     rd_en;
  logic [NB*AW-1:0]  rd_addr;
  logic [DW-1:0]     data_out;
  logic [NB-1:0]     data_vld;
  logic              rd_release, rd_err;

  typedef struct packed {
    logic [NB-1:0] vld;
    logic          err;
    logic [NB-1:0] mask;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  logic [NB-1:0]    v_en, v_ok;
  logic [NB*AW-1:0] v_addr;
  logic [DW-1:0]    v_exp;

  always #5 clk = ~clk;

  dfu_pingpong_banks #(
    .NUM_BANKS (NB),
    .ES        (ES),
    .DEPTH     (DEPTH),
    .ADDR_W    (AW),
    .DATA_W    (DW)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .ar2dfu_data_in           (ar2dfu_data_in),
    .wr_valid                 (wr_valid),
    .wr_last                  (wr_last),
    .wr_ready                 (wr_ready),
    .wr_set                   (wr_set),
    .rd_set                   (rd_set),
    .set_rdy                  (set_rdy),
    .rd_len                   (rd_len),
    .dfu2ip_sram_rd_en        (rd_en),
    .dfu2ip_sram_rd_addr      (rd_addr),
    .dfu2op_sram_data_out     (data_out),
    .dfu2op_sram_data_out_vld (data_vld),
    .rd_release               (rd_release),
    .rd_err                   (rd_err)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic st(input string n, input logic e_wr, input logic e_ws, input logic e_rs,
                    input logic e_sr, input int e_len);
    chk({n, "_wr_ready"}, DW'(wr_ready), DW'(e_wr));
    chk({n, "_wr_set"},   DW'(wr_set),   DW'(e_ws));
    chk({n, "_rd_set"},   DW'(rd_set),   DW'(e_rs));
    chk({n, "_set_rdy"},  DW'(set_rdy),  DW'(e_sr));
    chk({n, "_rd_len"},   DW'(rd_len),   DW'(e_len));
  endtask

  // Beat pattern: bank k element = {tag, k, beat}.
  function automatic logic [DW-1:0] mk_beat(input logic [3:0] tag, input int b);
    logic [DW-1:0] d;
    for (int k = 0; k < NB; k++) d[k*ES +: ES] = {tag, 4'(k), 8'(b)};
    return d;
  endfunction

  // Drive a beat and return at the negedge after the edge that accepted it.
  task automatic put_beat(input logic [3:0] tag, input int b, input logic last);
    int n;
    n = 0;
    wr_valid = 1'b1;
    wr_last = last;
    ar2dfu_data_in = mk_beat(tag, b);
    while (!wr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!wr_ready) chk("wr_accept_timeout", DW'(wr_ready), DW'(1));
    @(negedge clk);
  endtask

  task automatic wr_idle();
    wr_valid = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic rd_clear();
    v_en = '0; v_ok = '0; v_addr = '0; v_exp = '0;
  endtask

  task automatic rd_add(input int bank, input int addr, input logic ok, input logic [ES-1:0] exp);
    v_en[bank] = 1'b1;
    v_ok[bank] = ok;
    v_addr[bank*AW +: AW] = AW'(addr);
    v_exp[bank*ES +: ES] = ok ? exp : '0;
  endtask

  task automatic rd_go(input logic rel);
    exp_t e;
    e.vld = v_ok; e.err = |(v_en & ~v_ok); e.mask = v_en; e.dat = v_exp;
    exp_q.push_back(e);
    rd_en = v_en;
    rd_addr = v_addr;
    rd_release = rel;
    @(negedge clk);
    rd_en = '0;
    rd_release = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every cycle that shows a read response consumes one expectation.
  always @(negedge clk) begin
    if (!rst && ((|data_vld) || rd_err)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rd_resp", DW'({data_vld, rd_err}), DW'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd_vld", DW'(data_vld), DW'(mon_e.vld));
        chk("rd_err", DW'(rd_err), DW'(mon_e.err));
        for (int k = 0; k < NB; k++)
          if (mon_e.mask[k])
            chk($sformatf("rd_dat_b%0d", k), DW'(data_out[k*ES +: ES]), DW'(mon_e.dat[k*ES +: ES]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ar2dfu_data_in = '0; wr_valid = 1'b0; wr_last = 1'b0;
    rd_en = '0; rd_addr = '0; rd_release = 1'b0;
    rd_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state, then a read with no readable set.
    st("reset", 1, 0, 0, 0, 0);
    chk("reset_vld", DW'(data_vld), DW'(0));
    chk("reset_err", DW'(rd_err), DW'(0));
    chk("reset_dat", data_out, DW'(0));
    rd_clear(); rd_add(0, 0, 0, 16'h0); rd_go(0);
    repeat (2) @(negedge clk);

    // Four-beat fill into set 0.
    for (int b = 0; b < 4; b++) put_beat(4'h0, b, b == 3);
    wr_idle();
    st("fill4", 1, 1, 0, 1, 4);
    rd_clear(); rd_add(2, 1, 1, 16'h0201); rd_go(0);
    rd_clear(); rd_add(0, 3, 1, 16'h0003); rd_add(7, 3, 1, 16'h0703); rd_add(4, 0, 1, 16'h0400); rd_go(0);
    rd_clear(); rd_add(0, 5, 0, 16'h0); rd_go(0);
    rd_clear(); rd_add(1, 0, 1, 16'h0100); rd_add(3, 4, 0, 16'h0); rd_go(0);
    repeat (2) @(negedge clk);

    // Fill set 1; on its last beat read set 0 and release it.
    put_beat(4'h1, 0, 0); put_beat(4'h1, 1, 0);
    st("set1_filling", 1, 1, 0, 1, 4);
    wr_valid = 1'b1; wr_last = 1'b1; ar2dfu_data_in = mk_beat(4'h1, 2);
    rd_clear(); rd_add(2, 2, 1, 16'h0202); rd_go(1);
    wr_idle();
    st("swap", 1, 0, 1, 1, 3);
    rd_clear(); rd_add(5, 2, 1, 16'h1502); rd_add(6, 3, 0, 16'h0); rd_go(0);
    repeat (2) @(negedge clk);

    // Reset in the middle of a fill.
    put_beat(4'h5, 0, 0); put_beat(4'h5, 1, 0);
    wr_valid = 1'b1; wr_last = 1'b0; ar2dfu_data_in = mk_beat(4'h5, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wr_idle();
    st("midrst", 1, 0, 0, 0, 0);
    chk("midrst_dat", data_out, DW'(0));
    chk("midrst_vld", DW'(data_vld), DW'(0));
    put_beat(4'h4, 0, 1);
    wr_idle();
    st("refill", 1, 1, 0, 1, 1);
    rd_clear(); rd_add(3, 0, 1, 16'h4300); rd_go(0);
    repeat (2) @(negedge clk);

    // Full-depth fill without wr_last closes itself.
    do_reset();
    for (int b = 0; b < DEPTH; b++) put_beat(4'h0, b, 0);
    wr_idle();
    st("autoclose", 1, 1, 0, 1, 256);
    rd_clear(); rd_add(7, 255, 1, 16'h07FF); rd_add(0, 0, 1, 16'h0000); rd_go(0);
    repeat (2) @(negedge clk);

    // Both sets full: write stalls until a release.
    do_reset();
    put_beat(4'h6, 0, 0); put_beat(4'h6, 1, 1); put_beat(4'h7, 0, 1);
    wr_valid = 1'b1; wr_last = 1'b1; ar2dfu_data_in = mk_beat(4'h3, 0);
    st("bothfull", 0, 0, 0, 1, 2);
    repeat (2) begin
      @(negedge clk);
      chk("stall_wr_ready", DW'(wr_ready), DW'(0));
    end
    rd_release = 1'b1;
    @(negedge clk);
    rd_release = 1'b0;
    st("released", 1, 0, 1, 1, 1);
    @(negedge clk);
    wr_idle();
    st("refill0", 0, 1, 1, 1, 1);
    rd_clear(); rd_add(1, 0, 1, 16'h7100); rd_go(1);
    st("rp0", 1, 1, 0, 1, 1);
    rd_clear(); rd_add(2, 0, 1, 16'h3200); rd_add(4, 1, 0, 16'h0); rd_go(0);
    repeat (2) @(negedge clk);
    rd_release = 1'b1; @(negedge clk); rd_release = 1'b0;
    st("rel2", 1, 1, 1, 0, 0);
    rd_release = 1'b1; @(negedge clk); rd_release = 1'b0;
    st("rel_ignored", 1, 1, 1, 0, 0);

    repeat (3) @(negedge clk);
    chk("pending_rd_resp", DW'(exp_q.size()), DW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
